// File: rtl/y86_prefetch_fetch.sv
// Y86-64 fetch stage: block-wide instruction prefetch into a byte queue, variable-length
// extraction at the queue head, jXX/call target following and stop-until-redirect handling.
module y86_prefetch_fetch #(
  parameter int unsigned FETCH_BYTES = 16,
  parameter int unsigned QUEUE_BYTES = 32,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  output logic                     imem_req_o,
  output logic [63:0]              imem_addr_o,
  input  logic                     imem_ready_i,
  input  logic                     imem_rvalid_i,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata_i,
  input  logic                     imem_error_i,
  input  logic                     redirect_i,
  input  logic [63:0]              redirect_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              pc_o,
  output logic [63:0]              valP_o,
  output logic [63:0]              predPC_o,
  output logic [3:0]               icode_o,
  output logic [3:0]               ifun_o,
  output logic [3:0]               rA_o,
  output logic [3:0]               rB_o,
  output logic [63:0]              valC_o,
  output logic [2:0]               stat_o
);

  localparam int unsigned CntW = $clog2(QUEUE_BYTES + 1);
  localparam int unsigned IdxW = $clog2(QUEUE_BYTES);
  localparam int QB = int'(QUEUE_BYTES);
  localparam int FB = int'(FETCH_BYTES);
  localparam logic [CntW-1:0] ReqMaxCnt = CntW'(QUEUE_BYTES - FETCH_BYTES);
  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  logic [7:0]      q_q [QUEUE_BYTES];
  logic [7:0]      q_d [QUEUE_BYTES];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     head_pc_q, head_pc_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic            stop_q, stop_d;
  logic            outst_q, outst_d;
  logic            drop_q, drop_d;
  logic            err_q, err_d;

  logic [3:0]  icode, ifun, len;
  logic        has_regids, has_valc, is_ins;
  logic [63:0] valc_raw, valc;
  logic        full, err_mode;
  logic        req_acc, accept, is_jump, halts, rsp, flush, push;
  int          pop_n, base;

  // Head decode
  always_comb begin
    icode      = q_q[0][7:4];
    ifun       = q_q[0][3:0];
    len        = 4'd1;
    has_regids = 1'b0;
    has_valc   = 1'b0;
    is_ins     = 1'b0;
    case (icode)
      4'h0, 4'h1, 4'h9: len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin
        len        = 4'd2;
        has_regids = 1'b1;
      end
      4'h7, 4'h8: begin
        len      = 4'd9;
        has_valc = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        len        = 4'd10;
        has_regids = 1'b1;
        has_valc   = 1'b1;
      end
      default: begin
        len    = 4'd1;
        is_ins = 1'b1;
      end
    endcase
    for (int k = 0; k < 8; k++) begin
      valc_raw[8*k +: 8] = has_regids ? q_q[k+2] : q_q[k+1];
    end
    valc = has_valc ? valc_raw : 64'h0;
  end

  assign full     = cnt_q >= CntW'(len);
  assign err_mode = err_q && !full;

  assign out_valid_o = !stop_q && (full || err_mode);

  // Partial instruction in front of a failed fetch reports ADR with neutral fields
  always_comb begin
    pc_o     = head_pc_q;
    icode_o  = icode;
    ifun_o   = ifun;
    rA_o     = has_regids ? q_q[1][7:4] : 4'hF;
    rB_o     = has_regids ? q_q[1][3:0] : 4'hF;
    valC_o   = valc;
    valP_o   = head_pc_q + 64'(len);
    predPC_o = (icode == 4'h7 || icode == 4'h8) ? valc : valP_o;
    stat_o   = is_ins ? StatIns : ((icode == 4'h0) ? StatHlt : StatAok);
    if (err_mode) begin
      icode_o  = 4'h0;
      ifun_o   = 4'h0;
      rA_o     = 4'hF;
      rB_o     = 4'hF;
      valC_o   = 64'h0;
      valP_o   = 64'h0;
      predPC_o = 64'h0;
      stat_o   = StatAdr;
    end
  end

  // No new fetches once an error is pending: bytes past the fault are never useful
  assign imem_req_o  = rst_n_i && !stop_q && !outst_q && !err_q && (cnt_q <= ReqMaxCnt);
  assign imem_addr_o = fetch_pc_q;

  assign req_acc = imem_req_o && imem_ready_i;
  assign accept  = out_valid_o && out_ready_i && !redirect_i;
  assign is_jump = !err_mode && (icode == 4'h7 || icode == 4'h8);
  assign halts   = (stat_o != StatAok) || (icode_o == 4'h9);
  assign rsp     = outst_q && imem_rvalid_i;
  assign flush   = redirect_i || (accept && (is_jump || halts));
  assign push    = rsp && !drop_q && !imem_error_i && !err_q && !stop_q && !flush;
  assign pop_n   = accept ? int'(len) : 0;

  // Byte queue: shift out popped bytes, then append the response behind what remains
  always_comb begin
    q_d  = q_q;
    base = int'(cnt_q) - pop_n;
    for (int i = 0; i < QB; i++) begin
      if (i + pop_n < QB) q_d[i] = q_q[IdxW'(i + pop_n)];
    end
    if (push) begin
      for (int k = 0; k < FB; k++) begin
        if (base + k >= 0 && base + k < QB) q_d[IdxW'(base + k)] = imem_rdata_i[8*k +: 8];
      end
    end
    if (flush) cnt_d = '0;
    else       cnt_d = CntW'(base + (push ? FB : 0));
  end

  always_comb begin
    outst_d    = (outst_q && !imem_rvalid_i) || req_acc;
    drop_d     = drop_q;
    err_d      = err_q;
    stop_d     = stop_q;
    head_pc_d  = head_pc_q;
    fetch_pc_d = fetch_pc_q;
    if (rsp && drop_q) drop_d = 1'b0;
    if (rsp && !drop_q && imem_error_i && !stop_q) err_d = 1'b1;
    if (req_acc) fetch_pc_d = fetch_pc_q + 64'(FETCH_BYTES);
    if (accept) begin
      head_pc_d = head_pc_q + 64'(len);
      if (halts) stop_d = 1'b1;
      // A taken jump leaves the faulting region, so a pending error no longer applies
      if (is_jump) begin
        head_pc_d  = valc;
        fetch_pc_d = valc;
        drop_d     = outst_d;
        err_d      = 1'b0;
      end
    end
    if (redirect_i) begin
      head_pc_d  = redirect_pc_i;
      fetch_pc_d = redirect_pc_i;
      drop_d     = outst_d;
      err_d      = 1'b0;
      stop_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      head_pc_q  <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      stop_q     <= 1'b0;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      head_pc_q  <= head_pc_d;
      fetch_pc_q <= fetch_pc_d;
      stop_q     <= stop_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  // Queue storage needs no reset; cnt_q qualifies every byte
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

endmodule

// File: tb/tb_y86_prefetch_fetch.sv
// Directed bench for y86_prefetch_fetch with a latency-programmable byte memory model.
module tb_y86_prefetch_fetch;

  localparam int FB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [63:0]   imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [8*FB-1:0] imem_rdata;
  logic          imem_error;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   pc, valp, predpc, valc;
  logic [3:0]    icode, ifun, ra, rb;
  logic [2:0]    stat;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [4096];
  int          mem_lat = 1;
  int          lat_cnt = 0;
  logic [63:0] paddr = '0;
  logic [63:0] err_lo = 64'hFFFF_FFFF;
  logic [63:0] err_hi = 64'hFFFF_FFFF;

  logic [63:0] c_pc, c_valp, c_pred, c_valc;
  logic [3:0]  c_icode, c_ifun, c_ra, c_rb;
  logic [2:0]  c_stat;

  always #5 clk = ~clk;

  y86_prefetch_fetch #(
    .FETCH_BYTES(16),
    .QUEUE_BYTES(32),
    .RESET_PC   (64'h0)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ready_i (imem_ready),
    .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i (imem_rdata),
    .imem_error_i (imem_error),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .pc_o         (pc),
    .valP_o       (valp),
    .predPC_o     (predpc),
    .icode_o      (icode),
    .ifun_o       (ifun),
    .rA_o         (ra),
    .rB_o         (rb),
    .valC_o       (valc),
    .stat_o       (stat)
  );

  // Memory: accepts one request, answers mem_lat cycles later
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    imem_error  <= 1'b0;
    if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_error  <= (paddr >= err_lo) && (paddr < err_hi);
        for (int k = 0; k < FB; k++) imem_rdata[8*k +: 8] <= mem[12'(paddr + 64'(k))];
      end
    end
    if (imem_req && imem_ready) begin
      lat_cnt <= mem_lat;
      paddr   <= imem_addr;
    end
  end

  task automatic fill_mem(input logic [7:0] b);
    for (int i = 0; i < 4096; i++) mem[i] = b;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [63:0] p);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = p;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  // Waits for one instruction, captures it and handshakes it
  task automatic get_instr(output logic ok);
    ok = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        c_pc = pc; c_valp = valp; c_pred = predpc; c_valc = valc;
        c_icode = icode; c_ifun = ifun; c_ra = ra; c_rb = rb; c_stat = stat;
        ok = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        break;
      end
    end
  endtask

  task automatic observe_quiet(input int n, output int valids, output int reqs);
    valids = 0;
    reqs   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) valids++;
      if (imem_req) reqs++;
    end
  endtask

  task automatic test_reset();
    fill_mem(8'h10);
    mem_lat = 1;
    rst_n = 1'b0;
    redirect = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      failures++;
      $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req,
               imem_addr);
    end
  endtask

  task automatic test_irmovq_halt();
    logic ok;
    int v, r;
    logic [7:0] prog [11] = '{8'h30, 8'hF0, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00};
    fill_mem(8'h10);
    for (int i = 0; i < 11; i++) mem[i] = prog[i];
    mem_lat = 1;
    do_reset();
    get_instr(ok);
    checks++;
    if (!ok || c_icode !== 4'h3 || c_ifun !== 4'h0 || c_ra !== 4'hF || c_rb !== 4'h0 ||
        c_valc !== 64'h1234 || c_pc !== 64'h0 || c_valp !== 64'd10 || c_stat !== 3'd1) begin
      failures++;
      $display("FAIL irmovq: got ok=%b ic=%h fn=%h rA=%h rB=%h valC=%h pc=%h valP=%h st=%0d expected 1 3 0 F 0 1234 0 a 1",
               ok, c_icode, c_ifun, c_ra, c_rb, c_valc, c_pc, c_valp, c_stat);
    end
    get_instr(ok);
    checks++;
    if (!ok || c_icode !== 4'h0 || c_pc !== 64'd10 || c_stat !== 3'd2 || c_valp !== 64'd11) begin
      failures++;
      $display("FAIL halt: got ok=%b ic=%h pc=%h st=%0d valP=%h expected 1 0 a 2 b",
               ok, c_icode, c_pc, c_stat, c_valp);
    end
    observe_quiet(20, v, r);
    checks++;
    if (v != 0 || r != 0) begin
      failures++; $display("FAIL halt_quiet: got valids=%0d reqs=%0d expected 0 0", v, r);
    end
  endtask

  task automatic test_jump();
    logic ok;
    logic found;
    fill_mem(8'h00);
    mem[0] = 8'h70; mem[1] = 8'h00; mem[2] = 8'h01;
    mem[12'h100] = 8'h10;
    mem_lat = 1;
    do_reset();
    get_instr(ok);
    checks++;
    if (!ok || c_icode !== 4'h7 || c_pred !== 64'h100 || c_valp !== 64'd9 ||
        c_valc !== 64'h100) begin
      failures++;
      $display("FAIL jmp: got ok=%b ic=%h predPC=%h valP=%h valC=%h expected 1 7 100 9 100",
               ok, c_icode, c_pred, c_valp, c_valc);
    end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        checks++;
        if (imem_addr !== 64'h100) begin
          failures++; $display("FAIL jmp_addr: got %h expected 100", imem_addr);
        end
      end
    end
    if (!found) begin
      checks++; failures++; $display("FAIL jmp_addr: got no request expected addr 100");
    end
    get_instr(ok);
    checks++;
    if (!ok || c_pc !== 64'h100 || c_icode !== 4'h1) begin
      failures++;
      $display("FAIL jmp_target: got ok=%b pc=%h ic=%h expected 1 100 1", ok, c_pc, c_icode);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic seen;
    logic [63:0] first_pc;
    int frozen_bad, bad;
    fill_mem(8'h00);
    for (int i = 0; i < 16; i++) begin
      mem[2*i]   = 8'h60;
      mem[2*i+1] = 8'(i);
    end
    mem_lat = 1;
    do_reset();
    seen = 1'b0;
    first_pc = '1;
    frozen_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first_pc = pc;
        end else if (pc !== first_pc || icode !== 4'h6) begin
          frozen_bad++;
        end
      end
    end
    checks++;
    if (!seen || first_pc !== 64'h0) begin
      failures++; $display("FAIL stall_first: got seen=%b pc=%h expected 1 0", seen, first_pc);
    end
    checks++;
    if (frozen_bad != 0) begin
      failures++; $display("FAIL stall_frozen: got %0d changes expected 0", frozen_bad);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL stall_req_off: got %b expected 0", imem_req);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      get_instr(ok);
      checks++;
      if (!ok || c_pc !== 64'(2*i) || c_icode !== 4'h6 || c_ra !== 4'(i / 16) ||
          c_rb !== 4'(i % 16) || c_valp !== 64'(2*i + 2)) begin
        failures++; bad++;
        $display("FAIL stream_%0d: got ok=%b pc=%h ic=%h rA=%h rB=%h valP=%h expected pc=%h",
                 i, ok, c_pc, c_icode, c_ra, c_rb, c_valp, 64'(2*i));
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    logic ok;
    fill_mem(8'h00);
    mem[12'h200] = 8'h20; mem[12'h201] = 8'h12;
    mem_lat = 6;
    do_reset();
    @(posedge clk);
    do_redirect(64'h200);
    get_instr(ok);
    checks++;
    if (!ok || c_pc !== 64'h200 || c_icode !== 4'h2 || c_ra !== 4'h1 || c_rb !== 4'h2 ||
        c_valp !== 64'h202) begin
      failures++;
      $display("FAIL redirect: got ok=%b pc=%h ic=%h rA=%h rB=%h valP=%h expected 1 200 2 1 2 202",
               ok, c_pc, c_icode, c_ra, c_rb, c_valp);
    end
    get_instr(ok);
    checks++;
    if (!ok || c_pc !== 64'h202 || c_stat !== 3'd2) begin
      failures++;
      $display("FAIL redirect_next: got ok=%b pc=%h st=%0d expected 1 202 2", ok, c_pc, c_stat);
    end
    mem_lat = 1;
  endtask

  task automatic test_fetch_error();
    logic ok;
    int v, r, bad;
    logic [7:0] imm [10] = '{8'h30, 8'hF2, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33,
                             8'h22, 8'h11};
    fill_mem(8'h10);
    for (int i = 0; i < 10; i++) mem[10 + i] = imm[i];
    err_lo = 64'd16;
    err_hi = 64'd32;
    mem_lat = 1;
    do_reset();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      get_instr(ok);
      if (!ok || c_pc !== 64'(i) || c_stat !== 3'd1 || c_icode !== 4'h1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL err_nops: got %0d bad instructions expected 0", bad);
    end
    get_instr(ok);
    checks++;
    if (!ok || c_stat !== 3'd3 || c_pc !== 64'd10) begin
      failures++;
      $display("FAIL err_adr: got ok=%b st=%0d pc=%h expected 1 3 a", ok, c_stat, c_pc);
    end
    observe_quiet(20, v, r);
    checks++;
    if (v != 0 || r != 0) begin
      failures++; $display("FAIL err_stop: got valids=%0d reqs=%0d expected 0 0", v, r);
    end
    do_redirect(64'h300);
    get_instr(ok);
    checks++;
    if (!ok || c_pc !== 64'h300 || c_stat !== 3'd1) begin
      failures++;
      $display("FAIL err_resume: got ok=%b pc=%h st=%0d expected 1 300 1", ok, c_pc, c_stat);
    end
    err_lo = 64'hFFFF_FFFF;
    err_hi = 64'hFFFF_FFFF;
  endtask

  task automatic test_invalid();
    logic ok;
    int v, r, bad;
    fill_mem(8'h10);
    mem[4] = 8'hC0;
    mem_lat = 1;
    do_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      get_instr(ok);
      if (!ok || c_pc !== 64'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL ins_prefix: got %0d bad instructions expected 0", bad);
    end
    get_instr(ok);
    checks++;
    if (!ok || c_icode !== 4'hC || c_stat !== 3'd4 || c_valp !== 64'd5 || c_pc !== 64'd4) begin
      failures++;
      $display("FAIL ins: got ok=%b ic=%h st=%0d valP=%h pc=%h expected 1 c 4 5 4",
               ok, c_icode, c_stat, c_valp, c_pc);
    end
    observe_quiet(20, v, r);
    checks++;
    if (v != 0) begin
      failures++; $display("FAIL ins_stop: got valids=%0d expected 0", v);
    end
    do_redirect(64'h0);
    get_instr(ok);
    checks++;
    if (!ok || c_pc !== 64'h0 || c_icode !== 4'h1 || c_stat !== 3'd1) begin
      failures++;
      $display("FAIL ins_resume: got ok=%b pc=%h ic=%h st=%0d expected 1 0 1 1",
               ok, c_pc, c_icode, c_stat);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    test_reset();
    test_irmovq_halt();
    test_jump();
    test_back_to_back();
    test_redirect_outstanding();
    test_fetch_error();
    test_invalid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
